spi_mode0_rx: RTL and testbench

- SPI mode 0 (CPOL=0, CPHA=0) receiver that consumes the SCLK/CS/DO lines driven by the team's SPI mode 0 transmitter FSM.
- Synchronises the serial lines into the local clock domain and deserialises MSB-first bytes.
- Buffers completed bytes in a small FIFO and presents them on a valid/ready stream to downstream logic.
- Reports overrun and framing errors.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_rx_fifo.sv | 58 +++++
 rtl/spi_mode0_rx.sv | 137 +++++++++++++
 tb/tb_spi_mode0_rx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode 0 receiver.
// Contents:
//   spi_rx_state_t  - receiver FSM state encoding
//   SPI_DATA_W_DEF  - default word width used by the receiver and its FIFO
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        PUSH
    } spi_rx_state_t;

    localparam int SPI_DATA_W_DEF = 8;

endpackage

// File: rtl/spi_rx_fifo.sv
// Small first-word-fall-through FIFO holding received SPI words.
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   wr_en, wr_data  push request and word
//   full            no free entry (a push is still accepted if a pop happens in the same cycle)
//   rd_en           pop request, ignored while empty
//   rd_data         head entry, zero while empty
//   empty           no entries stored
module spi_rx_fifo
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              do_rd;
    logic              do_wr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // Storage is not reset, so the head is masked to zero while nothing is held.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/spi_mode0_rx.sv
// SPI mode 0 (CPOL=0, CPHA=0) receiver. Synchronises SCLK/CS/MOSI into the clk
// domain, shifts MSB-first words on SCLK rising edges, buffers them in a FIFO and
// presents them on a valid/ready stream.
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   sclk, cs, mosi      asynchronous serial lines (cs active-low)
//   m_data, m_valid     FIFO head word and non-empty flag
//   m_ready             consumer accept
//   busy                registered ~cs_s
//   overrun             one-cycle pulse: completed word dropped, FIFO full
//   frame_err           one-cycle pulse: CS rose with a partial word pending
module spi_mode0_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              overrun,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sclk_s, cs_s, mosi_s, sclk_d, rise;

    // Synchroniser chain, one 3-bit flop per stage carrying {sclk, cs, mosi}.
    // Reset value keeps CS deasserted so nothing is received until CS falls.
    for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
        logic [2:0] q;
        if (g == 0) begin : g_first
            always_ff @(posedge clk or posedge rst) begin
                if (rst) q <= 3'b010;
                else     q <= {sclk, cs, mosi};
            end
        end else begin : g_next
            always_ff @(posedge clk or posedge rst) begin
                if (rst) q <= 3'b010;
                else     q <= g_sync[g-1].q;
            end
        end
    end

    assign {sclk_s, cs_s, mosi_s} = g_sync[SYNC_STAGES-1].q;
    assign rise = sclk_s && !sclk_d;

    spi_rx_state_t     state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt, cnt_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic              wr_en, fifo_full, fifo_empty, pop;
    logic              ovr_nxt, ferr_nxt;

    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        shreg_nxt = shreg;
        wr_en     = 1'b0;
        ovr_nxt   = 1'b0;
        ferr_nxt  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt   = '0;
                shreg_nxt = '0;
                if (!cs_s) state_nxt = RECV;
            end
            RECV: begin
                // CS deassertion wins over a coincident SCLK rise.
                if (cs_s) begin
                    ferr_nxt  = (bit_cnt != '0);
                    state_nxt = IDLE;
                end else if (rise) begin
                    shreg_nxt = {shreg[DATA_W-2:0], mosi_s};
                    cnt_nxt   = bit_cnt + CNT_W'(1);
                    if (bit_cnt == LAST_BIT) state_nxt = PUSH;
                end
            end
            PUSH: begin
                cnt_nxt = '0;
                if (fifo_full && !pop) ovr_nxt = 1'b1;
                else                   wr_en   = 1'b1;
                state_nxt = cs_s ? IDLE : RECV;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            sclk_d    <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= cnt_nxt;
            sclk_d    <= sclk_s;
            busy      <= !cs_s;
            overrun   <= ovr_nxt;
            frame_err <= ferr_nxt;
        end
    end

    // Shift register content is cleared in IDLE, so it needs no reset.
    always_ff @(posedge clk) begin
        shreg <= shreg_nxt;
    end

    spi_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (shreg),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (m_data),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_spi_mode0_rx.sv
// Self-checking bench for spi_mode0_rx: table-driven single-frame vectors,
// directed multi-byte / overrun / full+pop / reset sequences, and a randomized
// run scored against a queue of the bytes that were sent.
module tb_spi_mode0_rx;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int FIFO_DEPTH  = 4;
    localparam int HALF        = 4;   // SCLK = clk/8

    logic       clk = 1'b0;
    logic       rst, sclk, cs, mosi, m_ready;
    logic [7:0] m_data;
    logic       m_valid, busy, overrun, frame_err;

    always #5 clk = ~clk;

    spi_mode0_rx #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs        (cs),
        .mosi      (mosi),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .busy      (busy),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    int         n_chk = 0;
    int         n_pass = 0;
    int         ovr_cnt = 0;
    int         ferr_cnt = 0;
    logic [7:0] got_q[$];
    int         got_rd = 0;
    bit         rnd_rdy = 0;
    logic       mv_e1, mv_e2;
    logic [7:0] eq[$];

    // Observe handshakes and pulses away from the active edge.
    always @(negedge clk) begin
        if (m_valid === 1'b1 && m_ready === 1'b1) got_q.push_back(m_data);
        if (overrun === 1'b1) ovr_cnt++;
        if (frame_err === 1'b1) ferr_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd_rdy) m_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // Sends the top n bits of v MSB-first. On the last bit of a full word,
    // samples m_valid in the PUSH cycle and the cycle after, and optionally
    // raises m_ready for exactly the PUSH cycle.
    task automatic send_bits(input logic [7:0] v, input int n, input bit pop_in_push);
        for (int i = 0; i < n; i++) begin
            mosi = v[7-i];
            cyc(HALF);
            sclk = 1'b1;
            if (i == n - 1 && n == DATA_W) begin
                cyc(SYNC_STAGES + 1);
                mv_e1 = m_valid;
                if (pop_in_push) m_ready = 1'b1;
                cyc(1);
                mv_e2 = m_valid;
                if (pop_in_push) m_ready = 1'b0;
                cyc(HALF - SYNC_STAGES - 2);
            end else begin
                cyc(HALF);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        cs = 1'b0;
        cyc(HALF);
    endtask

    task automatic cs_high();
        cyc(HALF);
        cs = 1'b1;
        cyc(2 * HALF);
    endtask

    task automatic pop_all();
        m_ready = 1'b1;
        for (int i = 0; i < 20 && m_valid; i++) cyc(1);
        m_ready = 1'b0;
        cyc(1);
    endtask

    task automatic expect_pops(input string nm, input logic [7:0] e[$]);
        for (int i = 0; i < e.size(); i++) begin
            if (got_rd < got_q.size()) begin
                chk(nm, int'(got_q[got_rd]), int'(e[i]));
                got_rd++;
            end else begin
                chk({nm, " missing"}, -1, int'(e[i]));
            end
        end
        chk({nm, " extra"}, got_q.size() - got_rd, 0);
        got_rd = got_q.size();
    endtask

    typedef struct {
        int         nbits;
        logic [7:0] data;
        bit         exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int base_o, base_f, exp_ferr, nb, k;
        logic [7:0] d;
        logic [7:0] exp_q[$];

        tbl[0] = '{8, 8'hB1, 1'b1, 8'hB1, 0};
        tbl[1] = '{5, 8'hA8, 1'b0, 8'h00, 1};
        tbl[2] = '{8, 8'h81, 1'b1, 8'h81, 0};
        tbl[3] = '{0, 8'h00, 1'b0, 8'h00, 0};
        tbl[4] = '{8, 8'h00, 1'b1, 8'h00, 0};
        tbl[5] = '{1, 8'h80, 1'b0, 8'h00, 1};
        tbl[6] = '{8, 8'hFF, 1'b1, 8'hFF, 0};

        rst = 1'b0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; m_ready = 1'b0;
        #2 rst = 1'b1;
        cyc(3);
        chk("reset m_valid", int'(m_valid), 0);
        chk("reset m_data", int'(m_data), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset overrun", int'(overrun), 0);
        chk("reset frame_err", int'(frame_err), 0);
        rst = 1'b0;
        cyc(4);

        // Table-driven single frames.
        for (int t = 0; t < 7; t++) begin
            base_o = ovr_cnt;
            base_f = ferr_cnt;
            cs_low();
            chk($sformatf("vec%0d busy", t), int'(busy), 1);
            send_bits(tbl[t].data, tbl[t].nbits, 1'b0);
            if (tbl[t].nbits == DATA_W) begin
                chk($sformatf("vec%0d valid in PUSH", t), int'(mv_e1), 0);
                chk($sformatf("vec%0d valid at E+2", t), int'(mv_e2), 1);
            end
            cs_high();
            chk($sformatf("vec%0d idle busy", t), int'(busy), 0);
            chk($sformatf("vec%0d m_valid", t), int'(m_valid), int'(tbl[t].exp_valid));
            if (tbl[t].exp_valid) chk($sformatf("vec%0d m_data", t), int'(m_data), int'(tbl[t].exp_data));
            chk($sformatf("vec%0d frame_err", t), ferr_cnt - base_f, tbl[t].exp_ferr);
            chk($sformatf("vec%0d overrun", t), ovr_cnt - base_o, 0);
            pop_all();
            chk($sformatf("vec%0d drained", t), int'(m_valid), 0);
            eq.delete();
            if (tbl[t].exp_valid) eq.push_back(tbl[t].exp_data);
            expect_pops($sformatf("vec%0d pop", t), eq);
        end

        // Multi-byte frame filling the FIFO exactly.
        base_o = ovr_cnt;
        cs_low();
        send_bits(8'hA5, 8, 1'b0);
        send_bits(8'h3C, 8, 1'b0);
        send_bits(8'hFF, 8, 1'b0);
        send_bits(8'h00, 8, 1'b0);
        cs_high();
        chk("multi overrun", ovr_cnt - base_o, 0);
        chk("multi head", int'(m_data), 8'hA5);
        pop_all();
        eq = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        expect_pops("multi pop", eq);

        // Fifth byte into a full FIFO is dropped.
        base_o = ovr_cnt;
        cs_low();
        send_bits(8'hA5, 8, 1'b0);
        send_bits(8'h3C, 8, 1'b0);
        send_bits(8'hFF, 8, 1'b0);
        send_bits(8'h00, 8, 1'b0);
        send_bits(8'h77, 8, 1'b0);
        cs_high();
        chk("overrun count", ovr_cnt - base_o, 1);
        pop_all();
        eq = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        expect_pops("overrun pop", eq);

        // Full FIFO with a pop in the PUSH cycle: no drop.
        base_o = ovr_cnt;
        cs_low();
        send_bits(8'hA5, 8, 1'b0);
        send_bits(8'h3C, 8, 1'b0);
        send_bits(8'hFF, 8, 1'b0);
        send_bits(8'h00, 8, 1'b0);
        send_bits(8'h77, 8, 1'b1);
        cs_high();
        chk("fullpop valid in PUSH", int'(mv_e1), 1);
        chk("fullpop overrun", ovr_cnt - base_o, 0);
        pop_all();
        eq = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h77};
        expect_pops("fullpop seq", eq);

        // Reset in the middle of a byte, with a word already buffered.
        cs_low();
        send_bits(8'h11, 8, 1'b0);
        send_bits(8'hE0, 3, 1'b0);
        chk("pre-reset m_valid", int'(m_valid), 1);
        #3 rst = 1'b1;
        #1;
        chk("async rst m_valid", int'(m_valid), 0);
        chk("async rst m_data", int'(m_data), 0);
        chk("async rst busy", int'(busy), 0);
        cs = 1'b1;
        sclk = 1'b0;
        cyc(3);
        rst = 1'b0;
        base_f = ferr_cnt;
        cyc(8);
        cs_low();
        send_bits(8'h5A, 8, 1'b0);
        cs_high();
        chk("post-reset frame_err", ferr_cnt - base_f, 0);
        pop_all();
        eq = '{8'h5A};
        expect_pops("post-reset pop", eq);

        // Randomized frames with random consumer backpressure.
        base_o = ovr_cnt;
        base_f = ferr_cnt;
        exp_ferr = 0;
        exp_q.delete();
        rnd_rdy = 1'b1;
        for (int f = 0; f < 12; f++) begin
            cs_low();
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                d = 8'($urandom);
                send_bits(d, 8, 1'b0);
                exp_q.push_back(d);
            end
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(1, 7);
                send_bits(8'($urandom), k, 1'b0);
                exp_ferr++;
            end
            cs_high();
        end
        rnd_rdy = 1'b0;
        pop_all();
        expect_pops("rand seq", exp_q);
        chk("rand frame_err", ferr_cnt - base_f, exp_ferr);
        chk("rand overrun", ovr_cnt - base_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
